branch_pred_unit: RTL and testbench
===================================

// Module: branch_pred_unit
// PURPOSE
//  Next-generation branch control: resolves branches in EX and predicts them in ID.
//  - ID: table of 2-bit saturating counters (BHT) gives a taken prediction.
//  - EX: evaluates the same 9 branch_sel conditions, compares outcome with the ID
//    prediction, and raises a registered redirect on mispredict.
//  - Sits between the decoder (ID lookup) and the NPC mux / pipeline flush logic (EX).
// PARAMETERS
//  XLEN       32  datapath / PC width
//  BHT_DEPTH  64  BHT entries; power of two, >=4; index = pc[IDX_W+1:2], IDX_W=$clog2(BHT_DEPTH)
//  CNT_W      32  width of the branch / mispredict statistics counters
//  BTB_DEPTH  16  JALR target-buffer entries (used only with BPRED_BTB_EN); power of two
// PORTS
//  clk              in   1     clock, rising edge
//  rstn             in   1     asynchronous active-low reset
//  id_valid         in   1     ID holds a valid instruction
//  id_branch_sel    in   4     0 NPC,1 OFFPC,2 NEQ,3 EQ,4 SLT,5 ULT,6 SGT,7 UGT,8 JALR; 9-15 = NPC
//  id_pc            in   XLEN  ID instruction PC
//  id_imm           in   XLEN  ID sign-extended immediate
//  id_pred_taken    out  1     prediction (combinational)
//  id_pred_target   out  XLEN  predicted target (combinational)
//  ex_valid         in   1     EX holds a valid instruction
//  ex_branch_sel    in   4     as id_branch_sel
//  ex_sr1, ex_sr2   in   XLEN  operands
//  ex_imm, ex_pc    in   XLEN  immediate / PC of EX instruction
//  ex_pred_taken    in   1     id_pred_taken piped to EX
//  ex_pred_target   in   XLEN  id_pred_target piped to EX
//  redirect         out  1     registered: flush younger instructions, fetch redirect_pc
//  redirect_pc      out  XLEN  registered correct next PC
//  npc_mux_sel      out  2     registered: 00 PLUS4, 01 PC_OFFSET, 10 REG_OFFSET (11 reserved)
//  br_cnt, mis_cnt  out  CNT_W resolved-branch / mispredict counts, saturating at all-ones
// BEHAVIOUR
//  Reset: all BHT counters 2'b01 (weak not-taken); redirect=0, redirect_pc=0,
//  npc_mux_sel=00, br_cnt=0, mis_cnt=0; BTB valid bits cleared.
//  ID prediction (combinational, from registered state):
//  - sel 2-7: taken = BHT[idx][1]; target = id_pc+id_imm.
//  - sel 1: always taken, target id_pc+id_imm.
//  - sel 0/8/9-15: not taken, target id_pc+4.
//  - id_valid=0: outputs don't-care; driven not taken.
//  EX resolution:
//  - EQ/NEQ: sr1==sr2. SLT/SGT: $signed compare. ULT/UGT: unsigned compare.
//  - SGT/UGT are strict (false when equal).
//  - Targets: pc+imm (sel 1-7); JALR (sr1+imm)&~1. Adds wrap modulo 2^XLEN.
//  - Actual next PC = taken ? target : ex_pc+4.
//  - mispredict = taken!=ex_pred_taken, or (taken && target!=ex_pred_target).
//  - Cycle after valid EX: redirect<=mispredict; redirect_pc<=actual next PC;
//    npc_mux_sel<= 10 if JALR, 01 if taken, else 00. Latency 1; redirect is a 1-cycle pulse.
//  - br_cnt +1 for every valid sel 1-8; mis_cnt +1 per mispredict. Both stop at all-ones.
//  BHT update: valid EX with sel 2-7; counter at ex_pc index; +1 if taken (sat 11),
//  -1 if not (sat 00); written on the same clock edge as redirect.
//  Wrong-path kill: while redirect==1, ex_valid is ignored (no redirect, BHT, BTB or count update).
//  Same-cycle ID read and EX write of one index: ID sees the pre-update value (no bypass).
//  Reset mid-operation: pending redirect dropped; all state returns to reset values.
// CONFIGURATION
//  BPRED_BTB_EN defined: direct-mapped BTB (tag=pc[XLEN-1:2+$clog2(BTB_DEPTH)], target).
//  - ID sel 8 on valid tag hit: taken, target = stored target.
//  - Every valid EX JALR writes its entry with the actual target; a mispredicted JALR
//    therefore trains the BTB.
//  BPRED_BTB_EN undefined: no BTB storage; JALR always predicted not-taken,
//  so every JALR mispredicts.
// STRUCTURE
//  Package bpred_pkg: branch_sel localparams (NPC..JALR), NPC-mux encodings
//  (PLUS4, PC_OFFSET, REG_OFFSET, INTERRUPT), 2-bit counter init / saturate constants.
//  Sub-module bht_table: one async read port, one sync write port, counter saturation.
// TESTING
//  1 Reset, then EX BEQ sr1=sr2=5, pc=0x100, imm=0x20, pred 0 -> next cycle redirect=1,
//    redirect_pc=0x120, npc_mux_sel=01; BHT[0] becomes 10.
//  2 Train same BEQ taken 3x -> ID at 0x100 pred_taken=1, target 0x120; 4th taken -> redirect=0.
//  3 SLT sr1=0xFFFFFFFF, sr2=1 -> taken. ULT with same operands -> not taken.
//    SGT/UGT with sr1=sr2 -> not taken.
//  4 JALR sr1=0x2003, imm=4 -> redirect_pc=0x2006, npc_mux_sel=10.
//    BTB_EN: repeat -> ID predicts 0x2006 and EX gives no redirect.
//  5 Mispredict, then ex_valid=1 (mispredicting) in the redirect cycle -> no second
//    redirect, no br_cnt change.
//  6 Force mis_cnt to all-ones (CNT_W=4 build) and mispredict -> holds 0xF.
//    Assert rstn mid-redirect -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bpred_pkg.sv
// Shared constants for the branch prediction unit: branch_sel codes, NPC-mux
// encodings and 2-bit saturating counter helpers.
package bpred_pkg;

  localparam logic [3:0] BR_NPC   = 4'd0;
  localparam logic [3:0] BR_OFFPC = 4'd1;
  localparam logic [3:0] BR_NEQ   = 4'd2;
  localparam logic [3:0] BR_EQ    = 4'd3;
  localparam logic [3:0] BR_SLT   = 4'd4;
  localparam logic [3:0] BR_ULT   = 4'd5;
  localparam logic [3:0] BR_SGT   = 4'd6;
  localparam logic [3:0] BR_UGT   = 4'd7;
  localparam logic [3:0] BR_JALR  = 4'd8;

  localparam logic [1:0] NPC_PLUS4      = 2'b00;
  localparam logic [1:0] NPC_PC_OFFSET  = 2'b01;
  localparam logic [1:0] NPC_REG_OFFSET = 2'b10;
  localparam logic [1:0] NPC_INTERRUPT  = 2'b11;

  localparam logic [1:0] CNT_INIT   = 2'b01;
  localparam logic [1:0] CNT_SAT_HI = 2'b11;
  localparam logic [1:0] CNT_SAT_LO = 2'b00;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_SAT_HI) ? cnt : cnt + 2'd1;
    else       return (cnt == CNT_SAT_LO) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: 2-bit saturating counters with one asynchronous read
// port and one synchronous update port (no read/write bypass).
module bht_table
  import bpred_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  logic [1:0] cnt_q [DEPTH];

  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= cnt_next(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch predict (ID) and resolve (EX) unit with registered redirect.
// Optional JALR target buffer enabled by defining BPRED_BTB_EN.
module branch_pred_unit
  import bpred_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [3:0]       id_branch_sel,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_imm,
  output logic             id_pred_taken,
  output logic [XLEN-1:0]  id_pred_target,
  input  logic             ex_valid,
  input  logic [3:0]       ex_branch_sel,
  input  logic [XLEN-1:0]  ex_sr1,
  input  logic [XLEN-1:0]  ex_sr2,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [1:0]       npc_mux_sel,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic             redirect_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic [1:0]       npc_sel_q, npc_sel_d;
  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;
  logic [1:0]       bht_cnt;
  logic             ex_act, ex_taken, ex_mispredict, ex_is_br, ex_is_cond;
  logic [XLEN-1:0]  ex_target, ex_next_pc;
  logic             btb_hit;
  logic [XLEN-1:0]  btb_target;

  // A redirect in flight means EX holds a wrong-path instruction.
  assign ex_act     = ex_valid && !redirect_q;
  assign ex_is_cond = (ex_branch_sel >= BR_NEQ) && (ex_branch_sel <= BR_UGT);
  assign ex_is_br   = (ex_branch_sel >= BR_OFFPC) && (ex_branch_sel <= BR_JALR);

  bht_table #(.DEPTH(BHT_DEPTH)) u_bht (
    .clk        (clk),
    .rstn       (rstn),
    .rd_idx_i   (id_pc[IDX_W+1:2]),
    .rd_cnt_o   (bht_cnt),
    .wr_en_i    (ex_act && ex_is_cond),
    .wr_idx_i   (ex_pc[IDX_W+1:2]),
    .wr_taken_i (ex_taken)
  );

`ifdef BPRED_BTB_EN
  localparam int BTB_IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W     = XLEN - 2 - BTB_IDX_W;

  logic [BTB_DEPTH-1:0] btb_valid_q;
  logic [TAG_W-1:0]     btb_tag_q [BTB_DEPTH];
  logic [XLEN-1:0]      btb_tgt_q [BTB_DEPTH];
  logic [BTB_IDX_W-1:0] id_btb_idx, ex_btb_idx;

  assign id_btb_idx = id_pc[BTB_IDX_W+1:2];
  assign ex_btb_idx = ex_pc[BTB_IDX_W+1:2];
  assign btb_hit    = btb_valid_q[id_btb_idx] &&
                      (btb_tag_q[id_btb_idx] == id_pc[XLEN-1:BTB_IDX_W+2]);
  assign btb_target = btb_tgt_q[id_btb_idx];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) btb_valid_q <= '0;
    else if (ex_act && ex_branch_sel == BR_JALR) btb_valid_q[ex_btb_idx] <= 1'b1;
  end

  // Tag/target storage needs no reset; the valid bits gate every hit.
  always_ff @(posedge clk) begin
    if (ex_act && ex_branch_sel == BR_JALR) begin
      btb_tag_q[ex_btb_idx] <= ex_pc[XLEN-1:BTB_IDX_W+2];
      btb_tgt_q[ex_btb_idx] <= ex_target;
    end
  end
`else
  assign btb_hit    = 1'b0;
  assign btb_target = '0;
`endif

  always_comb begin
    id_pred_taken  = 1'b0;
    id_pred_target = id_pc + XLEN'(4);
    if (id_valid) begin
      case (id_branch_sel)
        BR_OFFPC: begin
          id_pred_taken  = 1'b1;
          id_pred_target = id_pc + id_imm;
        end
        BR_NEQ, BR_EQ, BR_SLT, BR_ULT, BR_SGT, BR_UGT: begin
          id_pred_taken  = bht_cnt[1];
          id_pred_target = id_pc + id_imm;
        end
        BR_JALR: begin
          if (btb_hit) begin
            id_pred_taken  = 1'b1;
            id_pred_target = btb_target;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ex_taken = 1'b0;
    case (ex_branch_sel)
      BR_OFFPC: ex_taken = 1'b1;
      BR_NEQ:   ex_taken = (ex_sr1 != ex_sr2);
      BR_EQ:    ex_taken = (ex_sr1 == ex_sr2);
      BR_SLT:   ex_taken = ($signed(ex_sr1) < $signed(ex_sr2));
      BR_ULT:   ex_taken = (ex_sr1 < ex_sr2);
      BR_SGT:   ex_taken = ($signed(ex_sr1) > $signed(ex_sr2));
      BR_UGT:   ex_taken = (ex_sr1 > ex_sr2);
      BR_JALR:  ex_taken = 1'b1;
      default:  ex_taken = 1'b0;
    endcase
  end

  assign ex_target     = (ex_branch_sel == BR_JALR) ? ((ex_sr1 + ex_imm) & ~XLEN'(1))
                                                    : (ex_pc + ex_imm);
  assign ex_next_pc    = ex_taken ? ex_target : (ex_pc + XLEN'(4));
  assign ex_mispredict = (ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target));
  assign npc_sel_d     = (ex_branch_sel == BR_JALR) ? NPC_REG_OFFSET :
                         ex_taken ? NPC_PC_OFFSET : NPC_PLUS4;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      npc_sel_q     <= NPC_PLUS4;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      redirect_q <= ex_act && ex_mispredict;
      if (ex_act) begin
        redirect_pc_q <= ex_next_pc;
        npc_sel_q     <= npc_sel_d;
        if (ex_is_br && br_cnt_q != {CNT_W{1'b1}}) br_cnt_q <= br_cnt_q + CNT_W'(1);
        if (ex_mispredict && mis_cnt_q != {CNT_W{1'b1}}) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
      end
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign npc_mux_sel = npc_sel_q;
  assign br_cnt      = br_cnt_q;
  assign mis_cnt     = mis_cnt_q;

endmodule

// File: tb/tb_branch_pred_unit.sv
// Directed self-checking bench for branch_pred_unit (4-bit statistics counters).
// Expectations follow BPRED_BTB_EN when the bench is built with that macro.
module tb_branch_pred_unit;
  import bpred_pkg::*;

`ifdef BPRED_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        id_valid = 1'b0;
  logic [3:0]  id_branch_sel = '0;
  logic [31:0] id_pc = '0, id_imm = '0;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_branch_sel = '0;
  logic [31:0] ex_sr1 = '0, ex_sr2 = '0, ex_imm = '0, ex_pc = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  npc_mux_sel;
  logic [3:0]  br_cnt, mis_cnt;

  int checks = 0;
  int failures = 0;
  int expBr = 0;
  int expMis = 0;

  branch_pred_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(4), .BTB_DEPTH(16)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid(id_valid), .id_branch_sel(id_branch_sel), .id_pc(id_pc), .id_imm(id_imm),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .ex_valid(ex_valid), .ex_branch_sel(ex_branch_sel), .ex_sr1(ex_sr1), .ex_sr2(ex_sr2),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .npc_mux_sel(npc_mux_sel),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bumpCounts(input logic [3:0] sel, input bit mis);
    if (sel >= BR_OFFPC && sel <= BR_JALR && expBr < 15) expBr++;
    if (mis && expMis < 15) expMis++;
  endtask

  task automatic checkState(input string tag, input bit expRed, input logic [31:0] expPc,
                            input logic [1:0] expNpc);
    checkOutput({tag, ".redirect"}, 32'(redirect), 32'(expRed));
    checkOutput({tag, ".redirect_pc"}, redirect_pc, expPc);
    checkOutput({tag, ".npc_mux_sel"}, 32'(npc_mux_sel), 32'(expNpc));
    checkOutput({tag, ".br_cnt"}, 32'(br_cnt), 32'(expBr));
    checkOutput({tag, ".mis_cnt"}, 32'(mis_cnt), 32'(expMis));
  endtask

  // One EX instruction for one cycle, then check the registered result.
  task automatic applyStimulus(input string tag, input logic [3:0] sel,
                               input logic [31:0] sr1, input logic [31:0] sr2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input bit pt, input logic [31:0] ptgt,
                               input bit expRed, input logic [31:0] expPc,
                               input logic [1:0] expNpc);
    ex_branch_sel = sel; ex_sr1 = sr1; ex_sr2 = sr2; ex_imm = imm; ex_pc = pc;
    ex_pred_taken = pt; ex_pred_target = ptgt; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    bumpCounts(sel, expRed);
    checkState(tag, expRed, expPc, expNpc);
  endtask

  task automatic idleCycle();
    ex_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle.redirect", 32'(redirect), 32'd0);
  endtask

  task automatic checkPredict(input string tag, input bit valid, input logic [3:0] sel,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input bit expTaken, input logic [31:0] expTgt);
    id_valid = valid; id_branch_sel = sel; id_pc = pc; id_imm = imm;
    #1;
    checkOutput({tag, ".taken"}, 32'(id_pred_taken), 32'(expTaken));
    if (valid) checkOutput({tag, ".target"}, id_pred_target, expTgt);
  endtask

  initial begin
    #12;
    checkState("reset", 1'b0, 32'h0, NPC_PLUS4);
    checkPredict("reset_bht", 1'b1, BR_EQ, 32'h100, 32'h20, 1'b0, 32'h120);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // BEQ taken but predicted not-taken; BHT[0] 01 -> 10
    applyStimulus("beq1", BR_EQ, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 32'h104, 1'b1, 32'h120, NPC_PC_OFFSET);
    checkPredict("beq1_pred", 1'b1, BR_EQ, 32'h100, 32'h20, 1'b1, 32'h120);
    idleCycle();
    applyStimulus("beq2", BR_EQ, 32'd5, 32'd5, 32'h20, 32'h100, 1'b1, 32'h120, 1'b0, 32'h120, NPC_PC_OFFSET);
    applyStimulus("beq3", BR_EQ, 32'd5, 32'd5, 32'h20, 32'h100, 1'b1, 32'h120, 1'b0, 32'h120, NPC_PC_OFFSET);
    checkPredict("beq_sat", 1'b1, BR_EQ, 32'h100, 32'h20, 1'b1, 32'h120);
    // Two not-taken outcomes walk the counter 11 -> 10 -> 01
    applyStimulus("beq_nt1", BR_EQ, 32'd5, 32'd6, 32'h20, 32'h100, 1'b1, 32'h120, 1'b1, 32'h104, NPC_PLUS4);
    idleCycle();
    checkPredict("beq_nt1_pred", 1'b1, BR_EQ, 32'h100, 32'h20, 1'b1, 32'h120);
    applyStimulus("beq_nt2", BR_EQ, 32'd5, 32'd6, 32'h20, 32'h100, 1'b1, 32'h120, 1'b1, 32'h104, NPC_PLUS4);
    idleCycle();
    checkPredict("beq_nt2_pred", 1'b1, BR_EQ, 32'h100, 32'h20, 1'b0, 32'h120);
    applyStimulus("beq_badtgt", BR_EQ, 32'd5, 32'd5, 32'h20, 32'h104, 1'b1, 32'h200, 1'b1, 32'h124, NPC_PC_OFFSET);
    idleCycle();

    applyStimulus("slt", BR_SLT, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h208, 1'b0, 32'h20C, 1'b1, 32'h248, NPC_PC_OFFSET);
    idleCycle();
    applyStimulus("ult", BR_ULT, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h208, 1'b0, 32'h20C, 1'b0, 32'h20C, NPC_PLUS4);
    applyStimulus("sgt_eq", BR_SGT, 32'd7, 32'd7, 32'h40, 32'h208, 1'b0, 32'h20C, 1'b0, 32'h20C, NPC_PLUS4);
    applyStimulus("ugt_eq", BR_UGT, 32'd7, 32'd7, 32'h40, 32'h208, 1'b0, 32'h20C, 1'b0, 32'h20C, NPC_PLUS4);
    applyStimulus("sgt", BR_SGT, 32'd1, 32'hFFFFFFFF, 32'h40, 32'h208, 1'b0, 32'h20C, 1'b1, 32'h248, NPC_PC_OFFSET);
    idleCycle();
    applyStimulus("ugt_neg_imm", BR_UGT, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 32'h30C, 1'b0, 32'h310, 1'b1, 32'h2FC, NPC_PC_OFFSET);
    idleCycle();

    applyStimulus("jalr1", BR_JALR, 32'h2003, 32'd0, 32'd4, 32'h400, 1'b0, 32'h404, 1'b1, 32'h2006, NPC_REG_OFFSET);
    idleCycle();
    checkPredict("jalr_pred", 1'b1, BR_JALR, 32'h400, 32'd4, BTB, BTB ? 32'h2006 : 32'h404);
    applyStimulus("jalr2", BR_JALR, 32'h2003, 32'd0, 32'd4, 32'h400, BTB, BTB ? 32'h2006 : 32'h404, !BTB, 32'h2006, NPC_REG_OFFSET);
    idleCycle();
    checkPredict("offpc_pred", 1'b1, BR_OFFPC, 32'h500, 32'h8, 1'b1, 32'h508);
    checkPredict("npc_pred", 1'b1, BR_NPC, 32'h500, 32'h8, 1'b0, 32'h504);
    checkPredict("novalid_pred", 1'b0, BR_OFFPC, 32'h500, 32'h8, 1'b0, 32'h0);

    // Wrong-path instruction presented during the redirect cycle is ignored
    applyStimulus("kill_a", BR_EQ, 32'd5, 32'd5, 32'h10, 32'h604, 1'b0, 32'h608, 1'b1, 32'h614, NPC_PC_OFFSET);
    ex_branch_sel = BR_EQ; ex_sr1 = 32'd5; ex_sr2 = 32'd5; ex_imm = 32'h10; ex_pc = 32'h700;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h704; ex_valid = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checkState("kill_b", 1'b0, 32'h614, NPC_PC_OFFSET);
    checkPredict("kill_bht", 1'b1, BR_EQ, 32'h100, 32'h20, 1'b0, 32'h120);

    // Same-cycle read/write of index 0: ID sees the old counter
    id_valid = 1'b1; id_branch_sel = BR_EQ; id_pc = 32'h100; id_imm = 32'h20;
    ex_branch_sel = BR_EQ; ex_sr1 = 32'd5; ex_sr2 = 32'd5; ex_imm = 32'h20; ex_pc = 32'h100;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h104; ex_valid = 1'b1;
    #1;
    checkOutput("nobypass.before", 32'(id_pred_taken), 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    bumpCounts(BR_EQ, 1'b1);
    checkState("nobypass", 1'b1, 32'h120, NPC_PC_OFFSET);
    checkOutput("nobypass.after", 32'(id_pred_taken), 32'd1);
    idleCycle();

    for (int i = 0; i < 16; i++) begin
      applyStimulus("sat", BR_EQ, 32'd5, 32'd5, 32'h10, 32'h804, 1'b0, 32'h808, 1'b1, 32'h814, NPC_PC_OFFSET);
      idleCycle();
    end
    checkOutput("mis_sat", 32'(mis_cnt), 32'hF);
    checkOutput("br_sat", 32'(br_cnt), 32'hF);

    // Reset asserted while a redirect is pending
    applyStimulus("pre_reset", BR_EQ, 32'd5, 32'd5, 32'h10, 32'h804, 1'b0, 32'h808, 1'b1, 32'h814, NPC_PC_OFFSET);
    rstn = 1'b0;
    #1;
    expBr = 0; expMis = 0;
    checkState("async_reset", 1'b0, 32'h0, NPC_PLUS4);
    checkPredict("async_reset_bht", 1'b1, BR_EQ, 32'h100, 32'h20, 1'b0, 32'h120);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    checkState("post_reset", 1'b0, 32'h0, NPC_PLUS4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
